// File: rtl/aes_pkg.sv
// Shared AES decrypt-side helpers: GF(2^8) arithmetic, inverse S-box, FSM state and legal round counts.
package aes_pkg;

  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] mul11(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] mul13(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] mul14(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Undo the affine map, then invert in GF(2^8) as y^254 (0 maps to 0).
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    logic [7:0] sq;
    logic [7:0] p;
    y  = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    sq = y;
    p  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      p  = gf_mul(p, sq);
    end
    return p;
  endfunction

endpackage

// File: rtl/inv_shift_rows.sv
// InvShiftRows: row r rotates right by r columns, out(r,c) = in(r,(c-r) mod 4).
module inv_shift_rows (
  input  logic [127:0] state_i,
  output logic [127:0] state_o
);

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign state_o[32*c+8*r +: 8] = state_i[32*((c-r+4)%4)+8*r +: 8];
    end
  end

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES inverse cipher, one round per cycle; round keys are fetched through rk_idx/rk.
// Define AES_INV_PIPE_SBOX_EN to register the InvSubBytes output (two cycles per round).
module aes_inv_cipher
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block
);

  aes_state_e   fsm_q;
  logic [3:0]   cnt_q;
  logic [127:0] st_q;
  logic [127:0] isr;
  logic [127:0] sb;
  logic [127:0] sb_src;
  logic [127:0] ark;
  logic [127:0] mixed;
  logic [127:0] nxt;
  logic         round_fire;

  function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a3, a2, a1, a0} = a;
    return {mul11(a0) ^ mul13(a1) ^ mul9(a2)  ^ mul14(a3),
            mul13(a0) ^ mul9(a1)  ^ mul14(a2) ^ mul11(a3),
            mul9(a0)  ^ mul14(a1) ^ mul11(a2) ^ mul13(a3),
            mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3)};
  endfunction

  inv_shift_rows u_isr (
    .state_i(st_q),
    .state_o(isr)
  );

  for (genvar b = 0; b < 16; b++) begin : g_sbox
    assign sb[8*b +: 8] = inv_sbox(isr[8*b +: 8]);
  end

`ifdef AES_INV_PIPE_SBOX_EN
  logic         phase_q;
  logic [127:0] sb_q;

  // Phase 0 captures InvSubBytes, phase 1 finishes the round with the same rk.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= 1'b0;
      sb_q    <= '0;
    end else if (fsm_q == ROUND) begin
      phase_q <= ~phase_q;
      if (!phase_q) sb_q <= sb;
    end else begin
      phase_q <= 1'b0;
    end
  end

  assign sb_src     = sb_q;
  assign round_fire = phase_q;
`else
  assign sb_src     = sb;
  assign round_fire = 1'b1;
`endif

  assign ark = sb_src ^ rk;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mixed[32*c +: 32] = inv_mix_col(ark[32*c +: 32]);
  end

  assign nxt       = (cnt_q == 4'd0) ? ark : mixed;
  assign out_block = out_valid ? st_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= IDLE;
      cnt_q     <= 4'd0;
      st_q      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      rk_idx    <= 4'(NR);
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            st_q     <= in_block ^ rk;
            cnt_q    <= 4'(NR - 1);
            rk_idx   <= 4'(NR - 1);
            in_ready <= 1'b0;
            fsm_q    <= ROUND;
          end
        end
        ROUND: begin
          if (round_fire) begin
            st_q <= nxt;
            if (cnt_q == 4'd0) begin
              rk_idx    <= 4'(NR);
              out_valid <= 1'b1;
              fsm_q     <= DONE;
            end else begin
              cnt_q  <= cnt_q - 4'd1;
              rk_idx <= cnt_q - 4'd1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            fsm_q     <= IDLE;
          end
        end
        default: begin
          fsm_q     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          rk_idx    <= 4'(NR);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Bench for aes_inv_cipher: random plaintexts are encrypted by a forward AES-128 model and must decrypt back.
module tb_aes_inv_cipher;

  localparam int NR = 10;
`ifdef AES_INV_PIPE_SBOX_EN
  localparam int CPR = 2;
`else
  localparam int CPR = 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [7:0]   sbox [256];
  logic [127:0] rk_tab [16];

  always #5 clk = ~clk;

  aes_inv_cipher #(.NR(NR)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_block (in_block),
    .rk_idx   (rk_idx),
    .rk       (rk),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_block(out_block)
  );

  always_comb rk = rk_tab[rk_idx];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // Forward S-box from its definition: brute-force inverse, then the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int j = 1; j < 256; j++)
        if (x != 0 && gm(8'(x), 8'(j)) == 8'h01) inv = 8'(j);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // FIPS byte string (first byte most significant) -> state layout (first byte at [7:0]).
  function automatic logic [127:0] bswap(input logic [127:0] v);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = v[127-8*i -: 8];
    return o;
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k <= NR; k++)
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          rk_tab[k][32*c+8*r +: 8] = w[4*k+c][31-8*r -: 8];
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] s;
    logic [127:0] t;
    logic [7:0]   a [4];
    s = pt ^ rk_tab[0];
    for (int rd = 1; rd <= NR; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[32*c+8*r +: 8] = sbox[s[32*((c+r)%4)+8*r +: 8]];
      if (rd != NR)
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = t[32*c+8*r +: 8];
          for (int r = 0; r < 4; r++)
            t[32*c+8*r +: 8] = gm(a[r], 8'h02) ^ gm(a[(r+1)%4], 8'h03) ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
      s = t ^ rk_tab[rd];
    end
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge; returns at a negedge with the block transferred out.
  task automatic run_block(input logic [127:0] ct, input logic [127:0] pt, input int stall,
                           input bit glitch, input bit trace);
    int k;
    bit seen;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("in_ready_before_accept", 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    in_block = ct;
    @(negedge clk);
    in_valid = 1'b0;
    in_block = rnd128();
    k = 0;
    seen = 1'b0;
    while (k < 4*NR*CPR) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      if (trace) chk("rk_idx_seq", 128'(rk_idx), 128'(NR - 1 - k/CPR));
      if (glitch && k == 3) begin
        in_valid = 1'b1;
        in_block = rnd128();
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    in_valid = 1'b0;
    chk("latency", seen ? 128'(k) : '1, 128'(NR*CPR));
    chk("out_block", out_block, pt);
    if (trace) chk("rk_idx_done", 128'(rk_idx), 128'(NR));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_out_valid", 128'(out_valid), 128'(1));
      chk("stall_out_block", out_block, pt);
      chk("stall_in_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_xfer", 128'(in_ready), 128'(1));
    chk("out_valid_after_xfer", 128'(out_valid), 128'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pt;
    logic [127:0] ct;
    int k;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_block  = '0;
    for (int i = 0; i < 16; i++) rk_tab[i] = '0;
    build_sbox();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_block", out_block, '0);
    chk("rst_rk_idx", 128'(rk_idx), 128'(NR));

    // FIPS-197 C.1 with round-key index trace
    expand_key(128'h000102030405060708090a0b0c0d0e0f);
    run_block(bswap(128'h69c4e0d86a7b0430d8cdb78070b4c55a),
              bswap(128'h00112233445566778899aabbccddeeff), 0, 1'b0, 1'b1);

    // FIPS-197 Appendix B with 5 cycles of output backpressure
    expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    run_block(bswap(128'h3925841d02dc09fbdc118597196a0b32),
              bswap(128'h3243f6a8885a308d313198a2e0370734), 5, 1'b0, 1'b0);

    // in_valid pulse mid-decrypt must be ignored
    expand_key(rnd128());
    pt = rnd128();
    run_block(encrypt(pt), pt, 0, 1'b1, 1'b0);

    // reset while round key 5 is in use
    expand_key(rnd128());
    pt = rnd128();
    ct = encrypt(pt);
    in_valid = 1'b1;
    in_block = ct;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (rk_idx != 4'd5 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("reach_rk5", 128'(rk_idx), 128'(5));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_out_block", out_block, '0);
    chk("midrst_rk_idx", 128'(rk_idx), 128'(NR));
    run_block(ct, pt, 0, 1'b0, 1'b0);

    for (int n = 0; n < 8; n++) begin
      expand_key(rnd128());
      pt = rnd128();
      run_block(encrypt(pt), pt, int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes_inv_cipher.md
AES_INV_CIPHER -- requirements
Module: aes_inv_cipher

Interface
REQ-001 SHALL have parameter NR, default 10, number of rounds; legal values are 10, 12 and 14.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: a ciphertext block is offered.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepts input; high only in IDLE.
REQ-006 SHALL have port in_block, input, 128 bits: ciphertext state.
REQ-007 SHALL have port rk_idx, output, 4 bits: index of the round key required this cycle.
REQ-008 SHALL have port rk, input, 128 bits: round key for rk_idx, supplied combinationally in the same cycle.
REQ-009 SHALL have port out_valid, output, 1 bit: plaintext is available.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the plaintext.
REQ-011 SHALL have port out_block, output, 128 bits: plaintext state.

Function
REQ-012 SHALL place state byte (row r, column c) at bits [32c+8r+7 : 32c+8r] on in_block, rk and out_block; this is the same layout used by the encrypt path.
REQ-013 SHALL implement InvShiftRows as out(r,c) = in(r,(c-r) mod 4), i.e. the exact inverse of the encrypt-side ShiftRows.
REQ-014 SHALL use the FSM states IDLE, ROUND and DONE.
REQ-015 SHALL define acceptance as in_valid AND in_ready at a rising edge; on acceptance the state register loads in_block XOR rk (rk_idx = NR in IDLE), the round counter loads NR-1, and the FSM moves to ROUND.
REQ-016 SHALL, in ROUND with counter r, drive rk_idx = r and compute InvShiftRows, then InvSubBytes, then AddRoundKey(rk), then InvMixColumns; InvMixColumns is skipped when r = 0.
REQ-017 SHALL decrement r each ROUND cycle and go ROUND -> DONE after the r = 0 cycle.
REQ-018 SHALL, in DONE, hold out_valid = 1 with out_block stable until out_valid AND out_ready, then go to IDLE.
REQ-019 SHALL have latency as follows: if acceptance happens at edge T, out_valid is first high in the cycle following edge T+NR; throughput is one block per NR+2 cycles when out_ready is held high.
REQ-020 SHALL ignore in_valid while not in IDLE, with no state change.
REQ-021 SHALL drive rk_idx = NR in IDLE and DONE.
REQ-022 SHALL compute all GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1 and use the fixed InvMixColumns coefficients {0e,0b,0d,09}.

Reset
REQ-023 SHALL, when rst is high at a rising edge, force the FSM to IDLE, the counter to 0 and the state register to 0, overriding any other event in that cycle.
REQ-024 SHALL give these output values in the cycle after reset: in_ready = 1, out_valid = 0, out_block = 0, rk_idx = NR.
REQ-025 SHALL discard any in-flight block when reset is applied mid-operation; no partial result is ever presented.

Configuration
REQ-026 SHALL, when macro AES_INV_PIPE_SBOX_EN is defined, register the InvSubBytes output so that each round takes 2 cycles, with rk_idx held for both cycles; latency becomes out_valid high in the cycle following edge T+2NR.
REQ-027 SHALL, when AES_INV_PIPE_SBOX_EN is undefined, complete one round per cycle per REQ-016 to REQ-019.

Structure
REQ-028 SHALL place in shared package aes_pkg: the inverse S-box table/function, the xtime and mul9/mul11/mul13/mul14 functions, the FSM state enum, and the legal-NR constants.
REQ-029 SHALL instantiate one combinational sub-module, inv_shift_rows (128-bit in, 128-bit out); all other logic is inline.

Verification
REQ-030 SHALL cover FIPS-197 C.1: NR=10, key 000102..0f schedule on rk, in_block bytes 69c4e0d86a7b0430d8cdb78070b4c55a (byte0 = 69 at [7:0]) -> out_block bytes 00112233445566778899aabbccddeeff at T+11.
REQ-031 SHALL cover FIPS-197 Appendix B: key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32 -> plaintext 3243f6a8885a308d313198a2e0370734.
REQ-032 SHALL cover backpressure: out_ready low for 5 cycles in DONE -> out_valid = 1, out_block constant, in_ready = 0; on out_ready = 1 the block transfers and in_ready = 1 on the next cycle.
REQ-033 SHALL cover reset at rk_idx = 5 -> next cycle in_ready = 1, out_valid = 0, out_block = 0, rk_idx = 10; the next vector still decrypts correctly.
REQ-034 SHALL cover a second in_valid pulse with a different block during ROUND -> ignored; the first result is unchanged.
REQ-035 SHALL, with AES_INV_PIPE_SBOX_EN defined, rerun REQ-030 -> same plaintext at T+21, each rk_idx value held for 2 cycles.
